// File: rtl/jt900h_rfile_pkg.sv
// rtl/jt900h_rfile_pkg.sv - size codes, address field offsets and lane helpers for jt900h_rfile
package jt900h_rfile_pkg;

  localparam logic [1:0] BYTE_SZ = 2'b00;
  localparam logic [1:0] WORD_SZ = 2'b01;
  localparam logic [1:0] LONG_SZ = 2'b10;

  localparam int LANE_LSB = 0;
  localparam int REG_LSB  = 2;
  localparam int BANK_LSB = 4;

  // Pick the addressed lane, move it to bit 0 and extend to 32 bits.
  function automatic logic [31:0] lane_read(input logic [31:0] v, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic sex);
    logic [7:0]  b;
    logic [15:0] w;
    logic [31:0] r;
    b = v[{lane, 3'b000} +: 8];
    w = v[{lane[1], 4'b0000} +: 16];
    case (sz)
      BYTE_SZ:         r = {{24{sex & b[7]}}, b};
      WORD_SZ:         r = {{16{sex & w[15]}}, w};
      LONG_SZ, 2'b11:  r = v;
      default:         r = v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] din,
                                             input logic [1:0] lane, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      BYTE_SZ: r[{lane, 3'b000} +: 8]     = din[7:0];
      WORD_SZ: r[{lane[1], 4'b0000} +: 16] = din[15:0];
      default: r = din;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt900h_rfile_if.sv
// rtl/jt900h_rfile_if.sv - register file read/write port bundle between ucode control and rfile
interface jt900h_rfile_if #(parameter int BW = 2);

  logic [BW+4:0] ra_addr;
  logic [1:0]    ra_sz;
  logic          ra_sex;
  logic [31:0]   ra_data;
  logic [BW+4:0] rb_addr;
  logic [1:0]    rb_sz;
  logic          rb_sex;
  logic [31:0]   rb_data;
  logic          wr_en;
  logic [BW+4:0] wr_addr;
  logic [1:0]    wr_sz;
  logic [31:0]   wr_data;

  modport master (
    output ra_addr, ra_sz, ra_sex, rb_addr, rb_sz, rb_sex,
    output wr_en, wr_addr, wr_sz, wr_data,
    input  ra_data, rb_data
  );

  modport slave (
    input  ra_addr, ra_sz, ra_sex, rb_addr, rb_sz, rb_sex,
    input  wr_en, wr_addr, wr_sz, wr_data,
    output ra_data, rb_data
  );

endinterface

// File: rtl/jt900h_rfp_stack.sv
// rtl/jt900h_rfp_stack.sv - {rfp,imask} LIFO for interrupt entry/RETI with level and sticky error
module jt900h_rfp_stack #(
  parameter int BW    = 2,
  parameter int DEPTH = 4,
  parameter int IMW   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         push,
  input  logic [IMW-1:0]               push_mask,
  input  logic                         pop,
  input  logic                         rfp_ld,
  input  logic [BW-1:0]                rfp_din,
  output logic [BW-1:0]                rfp,
  output logic [IMW-1:0]               imask,
  output logic [$clog2(DEPTH+1)-1:0]   lvl,
  output logic                         err
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = BW + IMW;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [EW-1:0]  r_mem [0:(1<<LW)-1];
  logic [BW-1:0]  r_rfp;
  logic [IMW-1:0] r_imask;
  logic [LW-1:0]  r_lvl;
  logic           r_err;
  logic [LW-1:0]  w_top;

  assign w_top = r_lvl - 1'b1;

  // BANKS is a power of two, so the natural BW-bit wrap of rfp+1 is modulo BANKS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfp   <= '0;
      r_imask <= '1;
      r_lvl   <= '0;
      r_err   <= 1'b0;
    end else if (cen) begin
      if (push && !pop) begin
        if (r_lvl == FULL) begin
          r_err <= 1'b1;
        end else begin
          r_mem[r_lvl] <= {r_rfp, r_imask};
          r_lvl        <= r_lvl + 1'b1;
          r_rfp        <= r_rfp + 1'b1;
          r_imask      <= push_mask;
        end
      end else if (pop && !push) begin
        if (r_lvl == '0) begin
          r_err <= 1'b1;
        end else begin
          {r_rfp, r_imask} <= r_mem[w_top];
          r_lvl            <= w_top;
        end
      end else if (rfp_ld && !push && !pop) begin
        r_rfp <= rfp_din;
      end
    end
  end

  assign rfp   = r_rfp;
  assign imask = r_imask;
  assign lvl   = r_lvl;
  assign err   = r_err;

endmodule

// File: rtl/jt900h_rfile.sv
// rtl/jt900h_rfile.sv - banked 900H register file, flags and RFP stack top
// Optional same-cycle write forwarding into the read ports: JT900H_RF_BYPASS_EN.
module jt900h_rfile
  import jt900h_rfile_pkg::*;
#(
  parameter int BANKS = 4,
  parameter int DEPTH = 4,
  parameter int IMW   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  jt900h_rfile_if.slave                bus,
  input  logic [5:0]                   flg_we,
  input  logic [5:0]                   flg_din,
  input  logic                         exff,
  output logic [7:0]                   flags,
  input  logic                         rfp_ld,
  input  logic [$clog2(BANKS)-1:0]     rfp_din,
  input  logic                         push,
  input  logic [IMW-1:0]               push_mask,
  input  logic                         pop,
  output logic [$clog2(BANKS)-1:0]     rfp,
  output logic [IMW-1:0]               imask,
  output logic [$clog2(DEPTH+1)-1:0]   stk_lvl,
  output logic                         stk_err
);

  localparam int BW = $clog2(BANKS);
  localparam int IW = BW + 3;

  // Pointer registers share one slot set regardless of the bank field.
  function automatic logic [IW-1:0] reg_idx(input logic [BW+2:0] a);
    return {a[BW+2], a[BW+2] ? {BW{1'b0}} : a[BW+1:2], a[1:0]};
  endfunction

  logic [31:0]   r_regs [0:(1<<IW)-1];
  logic [IW-1:0] w_ra_idx, w_rb_idx, w_wr_idx;
  logic [31:0]   w_wr_merged, w_ra_raw, w_rb_raw;
  logic [5:0]    r_flg_main, r_flg_alt;
  logic [5:0]    w_main_pre, w_alt_nxt;

  assign w_ra_idx    = reg_idx(bus.ra_addr[BW+4:REG_LSB]);
  assign w_rb_idx    = reg_idx(bus.rb_addr[BW+4:REG_LSB]);
  assign w_wr_idx    = reg_idx(bus.wr_addr[BW+4:REG_LSB]);
  assign w_wr_merged = lane_merge(r_regs[w_wr_idx], bus.wr_data, bus.wr_addr[REG_LSB-1:LANE_LSB], bus.wr_sz);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << IW); i++) r_regs[i] <= '0;
    end else if (cen && bus.wr_en) begin
      r_regs[w_wr_idx] <= w_wr_merged;
    end
  end

`ifdef JT900H_RF_BYPASS_EN
  assign w_ra_raw = (cen && bus.wr_en && (w_ra_idx == w_wr_idx)) ? w_wr_merged : r_regs[w_ra_idx];
  assign w_rb_raw = (cen && bus.wr_en && (w_rb_idx == w_wr_idx)) ? w_wr_merged : r_regs[w_rb_idx];
`else
  assign w_ra_raw = r_regs[w_ra_idx];
  assign w_rb_raw = r_regs[w_rb_idx];
`endif

  assign bus.ra_data = lane_read(w_ra_raw, bus.ra_addr[1:0], bus.ra_sz, bus.ra_sex);
  assign bus.rb_data = lane_read(w_rb_raw, bus.rb_addr[1:0], bus.rb_sz, bus.rb_sex);

  // The exchange happens before the masked load, so flg_we targets the post-swap main set.
  assign w_main_pre = exff ? r_flg_alt : r_flg_main;
  assign w_alt_nxt  = exff ? r_flg_main : r_flg_alt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flg_main <= '0;
      r_flg_alt  <= '0;
    end else if (cen) begin
      r_flg_main <= (w_main_pre & ~flg_we) | (flg_din & flg_we);
      r_flg_alt  <= w_alt_nxt;
    end
  end

  assign flags = {r_flg_main[5], r_flg_main[4], 1'b0, r_flg_main[3], 1'b0, r_flg_main[2:0]};

  jt900h_rfp_stack #(.BW(BW), .DEPTH(DEPTH), .IMW(IMW)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .push      (push),
    .push_mask (push_mask),
    .pop       (pop),
    .rfp_ld    (rfp_ld),
    .rfp_din   (rfp_din),
    .rfp       (rfp),
    .imask     (imask),
    .lvl       (stk_lvl),
    .err       (stk_err)
  );

endmodule

// File: tb/tb_jt900h_rfile.sv
// tb/tb_jt900h_rfile.sv - self-checking bench for jt900h_rfile against a byte-array reference model
module tb_jt900h_rfile;

  localparam int BANKS = 4;
  localparam int DEPTH = 4;
  localparam int IMW   = 3;
  localparam int BW    = 2;
  localparam int NM    = BANKS*4 + 4;

  logic           clk = 1'b0;
  logic           rst, cen;
  logic [5:0]     flg_we, flg_din;
  logic           exff, rfp_ld, push, pop;
  logic [BW-1:0]  rfp_din;
  logic [IMW-1:0] push_mask;
  logic [7:0]     flags;
  logic [BW-1:0]  rfp;
  logic [IMW-1:0] imask;
  logic [2:0]     stk_lvl;
  logic           stk_err;

  jt900h_rfile_if #(.BW(BW)) bus();

  jt900h_rfile #(.BANKS(BANKS), .DEPTH(DEPTH), .IMW(IMW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus),
    .flg_we(flg_we), .flg_din(flg_din), .exff(exff), .flags(flags),
    .rfp_ld(rfp_ld), .rfp_din(rfp_din), .push(push), .push_mask(push_mask), .pop(pop),
    .rfp(rfp), .imask(imask), .stk_lvl(stk_lvl), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [7:0] m_b [0:NM-1][0:3];
  logic [5:0] m_main, m_alt;
  int         m_rfp, m_imask;
  bit         m_err;
  int         m_stk[$];

  function automatic logic [6:0] mk(int p, int b, int r, int l);
    return {1'(p), 2'(b), 2'(r), 2'(l)};
  endfunction

  function automatic int midx(logic [6:0] a);
    return a[6] ? BANKS*4 + int'(a[3:2]) : int'(a[5:4])*4 + int'(a[3:2]);
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int first_byte(logic [1:0] sz, logic [1:0] lane);
    return (sz == 2'd0) ? int'(lane) : (sz == 2'd1) ? int'(lane) & 2 : 0;
  endfunction

  function automatic logic [31:0] model_read(logic [6:0] a, logic [1:0] sz, logic sex);
    logic [7:0]  t [0:3];
    logic [31:0] v;
    int r, n, b;
    r = midx(a);
    for (int k = 0; k < 4; k++) t[k] = m_b[r][k];
`ifdef JT900H_RF_BYPASS_EN
    if (cen && bus.wr_en && midx(bus.wr_addr) == r) begin
      n = nbytes(bus.wr_sz);
      b = first_byte(bus.wr_sz, bus.wr_addr[1:0]);
      for (int k = 0; k < n; k++) t[b+k] = bus.wr_data[8*k +: 8];
    end
`endif
    n = nbytes(sz);
    b = first_byte(sz, a[1:0]);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = t[b+k];
    if (sex && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_step();
    int r, n, b, e;
    logic [5:0] tmp;
    if (rst) begin
      for (int i = 0; i < NM; i++) for (int k = 0; k < 4; k++) m_b[i][k] = 8'h00;
      m_main = '0; m_alt = '0; m_rfp = 0; m_imask = (1 << IMW) - 1; m_err = 1'b0;
      m_stk.delete();
    end else if (cen) begin
      if (bus.wr_en) begin
        r = midx(bus.wr_addr);
        n = nbytes(bus.wr_sz);
        b = first_byte(bus.wr_sz, bus.wr_addr[1:0]);
        for (int k = 0; k < n; k++) m_b[r][b+k] = bus.wr_data[8*k +: 8];
      end
      if (exff) begin tmp = m_main; m_main = m_alt; m_alt = tmp; end
      for (int i = 0; i < 6; i++) if (flg_we[i]) m_main[i] = flg_din[i];
      if (push && pop) begin
      end else if (push) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else begin
          m_stk.push_back(m_rfp * 8 + m_imask);
          m_rfp   = (m_rfp + 1) % BANKS;
          m_imask = int'(push_mask);
        end
      end else if (pop) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          e = m_stk.pop_back();
          m_rfp = e / 8; m_imask = e % 8;
        end
      end else if (rfp_ld) begin
        m_rfp = int'(rfp_din);
      end
    end
  endtask

  task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ra_data", bus.ra_data, model_read(bus.ra_addr, bus.ra_sz, bus.ra_sex));
      cmp("rb_data", bus.rb_data, model_read(bus.rb_addr, bus.rb_sz, bus.rb_sex));
      cmp("flags", 32'(flags), 32'({m_main[5], m_main[4], 1'b0, m_main[3], 1'b0, m_main[2:0]}));
      cmp("rfp", 32'(rfp), 32'(m_rfp));
      cmp("imask", 32'(imask), 32'(m_imask));
      cmp("stk_lvl", 32'(stk_lvl), 32'(m_stk.size()));
      cmp("stk_err", 32'(stk_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cen = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_sz = 2'd2; bus.wr_data = '0;
    bus.ra_addr = '0; bus.ra_sz = 2'd2; bus.ra_sex = 1'b0;
    bus.rb_addr = '0; bus.rb_sz = 2'd2; bus.rb_sex = 1'b0;
    flg_we = '0; flg_din = '0; exff = 1'b0; rfp_ld = 1'b0; rfp_din = '0;
    push = 1'b0; pop = 1'b0; push_mask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cmp("lit_reset_imask", 32'(imask), 32'h7);
    cmp("lit_reset_ra", bus.ra_data, 32'h0);

    bus.wr_en = 1'b1; bus.wr_addr = mk(0, 0, 0, 0); bus.wr_sz = 2'd2; bus.wr_data = 32'h89ABCDEF;
    tick();
    bus.wr_en = 1'b0;
    bus.ra_addr = mk(0, 0, 0, 3); bus.ra_sz = 2'd0; bus.ra_sex = 1'b1;
    bus.rb_addr = mk(0, 0, 0, 3); bus.rb_sz = 2'd0; bus.rb_sex = 1'b0;
    #1;
    cmp("lit_byte_sex", bus.ra_data, 32'hFFFFFF89);
    cmp("lit_byte_zex", bus.rb_data, 32'h00000089);

    rfp_ld = 1'b1; rfp_din = 2'd2;
    tick();
    rfp_ld = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = mk(0, 2, 1, 2); bus.wr_sz = 2'd1; bus.wr_data = 32'h00001234;
    tick();
    bus.wr_en = 1'b0;
    bus.ra_addr = mk(0, 2, 1, 0); bus.ra_sz = 2'd2; bus.ra_sex = 1'b0;
    bus.rb_addr = mk(0, 0, 1, 0); bus.rb_sz = 2'd3; bus.rb_sex = 1'b1;
    #1;
    cmp("lit_rfp_ld", 32'(rfp), 32'd2);
    cmp("lit_word_lane1", bus.ra_data, 32'h12340000);
    cmp("lit_other_bank", bus.rb_data, 32'h0);

    do_reset();
    push = 1'b1; push_mask = 3'd2;
    repeat (4) tick();
    cmp("lit_push4_rfp", 32'(rfp), 32'd0);
    cmp("lit_push4_lvl", 32'(stk_lvl), 32'd4);
    tick();
    push = 1'b0;
    cmp("lit_overflow_err", 32'(stk_err), 32'd1);
    cmp("lit_overflow_lvl", 32'(stk_lvl), 32'd4);

    do_reset();
    push = 1'b1; push_mask = 3'd5;
    tick();
    pop = 1'b1;
    tick();
    push = 1'b0;
    cmp("lit_pushpop_lvl", 32'(stk_lvl), 32'd1);
    cmp("lit_pushpop_rfp", 32'(rfp), 32'd1);
    cmp("lit_pushpop_imask", 32'(imask), 32'd5);
    tick();
    cmp("lit_pop_restore", 32'({rfp, imask}), 32'({2'd0, 3'd7}));
    tick();
    pop = 1'b0;
    cmp("lit_underflow_err", 32'(stk_err), 32'd1);

    do_reset();
    flg_we = 6'h3F; flg_din = 6'b100001;
    tick();
    exff = 1'b1; flg_we = 6'b010000; flg_din = 6'b010000;
    tick();
    exff = 1'b0; flg_we = '0;
    cmp("lit_exff_z", 32'(flags), 32'h40);
    exff = 1'b1;
    tick();
    exff = 1'b0;
    cmp("lit_exff_back", 32'(flags), 32'h81);

    bus.wr_en = 1'b1; bus.wr_addr = mk(0, 1, 3, 0); bus.wr_sz = 2'd2; bus.wr_data = 32'h11223344;
    tick();
    bus.wr_sz = 2'd0; bus.wr_data = 32'h000000AA;
    bus.ra_addr = mk(0, 1, 3, 0); bus.ra_sz = 2'd2;
    #1;
`ifdef JT900H_RF_BYPASS_EN
    cmp("lit_bypass", bus.ra_data, 32'h112233AA);
`else
    cmp("lit_no_bypass", bus.ra_data, 32'h11223344);
`endif
    tick();
    bus.wr_en = 1'b0;
    #1;
    cmp("lit_byte_merge", bus.ra_data, 32'h112233AA);

    bus.wr_en = 1'b1; bus.wr_addr = mk(1, 0, 2, 0); bus.wr_sz = 2'd2; bus.wr_data = 32'hCAFEF00D;
    tick();
    cen = 1'b0; bus.wr_addr = mk(0, 3, 0, 0); bus.wr_data = 32'hDEADBEEF; push = 1'b1;
    tick();
    cen = 1'b1; bus.wr_en = 1'b0; push = 1'b0;
    bus.ra_addr = mk(1, 3, 2, 0); bus.rb_addr = mk(0, 3, 0, 0); bus.rb_sz = 2'd2;
    #1;
    cmp("lit_ptr_shared", bus.ra_data, 32'hCAFEF00D);
    cmp("lit_cen_hold", bus.rb_data, 32'h0);
    cmp("lit_cen_stack", 32'(stk_lvl), 32'd0);

    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom % 150) == 0;
      cen          = ($urandom % 8) != 0;
      bus.wr_en    = 1'($urandom);
      bus.wr_addr  = 7'($urandom);
      bus.wr_sz    = 2'($urandom);
      bus.wr_data  = $urandom;
      bus.ra_addr  = (($urandom % 4) == 0) ? bus.wr_addr : 7'($urandom);
      bus.ra_sz    = 2'($urandom);
      bus.ra_sex   = 1'($urandom);
      bus.rb_addr  = (($urandom % 4) == 0) ? bus.wr_addr : 7'($urandom);
      bus.rb_sz    = 2'($urandom);
      bus.rb_sex   = 1'($urandom);
      flg_we       = 6'($urandom);
      flg_din      = 6'($urandom);
      exff         = ($urandom % 5) == 0;
      rfp_ld       = ($urandom % 8) == 0;
      rfp_din      = 2'($urandom);
      push         = ($urandom % 5) == 0;
      pop          = ($urandom % 5) == 0;
      push_mask    = 3'($urandom);
      tick();
    end

    idle();
    rst = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
